sfifo_1w_2r: RTL
================

# sfifo_1w_2r

Single-clock FIFO that accepts one entry per write and releases entries in pairs on each read. It is the mirror of the two-write/one-read FIFO and sits where a narrow producer, such as a single-lane SMEM result stream, feeds a consumer that processes two entries per cycle. Occupancy is tracked exactly, so Full_out and Empty_out are genuine flow-control signals.

## Interface
- DATA_WIDTH, 65: width of one entry.
- ADDRESS_WIDTH, 2: pointer width. Must be ≥ 2.
- FIFO_DEPTH, 1 << ADDRESS_WIDTH: number of entries. Always even.
- Clk  in  1  single clock; all logic is on posedge Clk.
- Clear_in  in  1  reset; synchronous, active-high.
- Data_in  in  DATA_WIDTH  entry to enqueue.
- WriteEn_in  in  1  write request. Accepted when Full_out = 0.
- Full_out  out  1  asserted when occupancy = FIFO_DEPTH.
- ReadEn_in  in  1  pair-read request. Accepted when Empty_out = 0.
- Empty_out  out  1  asserted when occupancy < 2, i.e. no complete pair is available.
- Data_out_1  out  DATA_WIDTH  older entry of the popped pair.
- Data_out_2  out  DATA_WIDTH  newer entry of the popped pair.
- Data_valid  out  1  one-cycle pulse qualifying Data_out_1 and Data_out_2.
- Count_out  out  ADDRESS_WIDTH+1  current occupancy, 0..FIFO_DEPTH.

## Operation
- Storage: Mem[FIFO_DEPTH]. Binary pointers wr_ptr and rd_ptr, plus an occupancy counter cnt. Pointers wrap modulo FIFO_DEPTH.
- Write accept: wr_acc = WriteEn_in & ~Full_out.
  - Mem[wr_ptr] <= Data_in.
  - wr_ptr += 1.
- Read accept: rd_acc = ReadEn_in & ~Empty_out.
  - Data_out_1 <= Mem[rd_ptr].
  - Data_out_2 <= Mem[rd_ptr+1].
  - rd_ptr += 2.
- rd_ptr is always even; Mem[rd_ptr+1] never wraps past the top of the array.
- Occupancy update: cnt_next = cnt + wr_acc − 2·rd_acc, computed in ADDRESS_WIDTH+1 bits. It never underflows or overflows.
- Full_out = (cnt == FIFO_DEPTH). Empty_out = (cnt < 2). Both are combinational from the registered cnt. Count_out = cnt.
- Data_valid <= rd_acc.
- Data_out_1/2 hold their previous value when rd_acc = 0.
- A request that is not accepted (write while full, read while empty) is dropped without side effects. The upstream must hold its request.
- Simultaneous write and read are both accepted when their own conditions hold:
  - cnt = 2, write + read → cnt = 1.
  - cnt = FIFO_DEPTH, write + read → write is dropped because Full_out is evaluated before the read; cnt = FIFO_DEPTH − 2.
- Odd leftover: with cnt = 1 the single entry stays until a second entry arrives. There is no partial-pair read.
- A write never targets the pair being read: the read locations are occupied, and wr_acc requires cnt < FIFO_DEPTH.

## Timing
- Reset values: cnt = 0, wr_ptr = 0, rd_ptr = 0, Data_out_1 = 0, Data_out_2 = 0, Data_valid = 0, so Full_out = 0, Empty_out = 1, Count_out = 0.
- Clear_in takes priority over any simultaneous request. A write in the Clear_in cycle is discarded and Data_valid is 0 the following cycle.
- Mem contents are not reset.
- Write-to-status latency: 1 cycle. Count_out reflects a write at cycle N from cycle N+1.
- Write-to-read latency: a pair completed at cycle N can be read at cycle N+1. Data is then presented at N+2 together with Data_valid.
- Read latency: data is registered. Data_valid and Data_out_1/2 appear the cycle after rd_acc.
- Throughput:
  - Sustained 1 write per cycle with a read every other cycle runs indefinitely with cnt ≤ 3.
  - Back-to-back reads are permitted while cnt ≥ 2.

## Structure
- The shared pipeline package holds the 65-bit SMEM entry width constant (default for DATA_WIDTH).
- Pointer widths and FIFO_DEPTH are local parameters of this module.
- One sub-module is natural: fifo_ptr_1w_2r, which holds wr_ptr, rd_ptr and cnt, with accept logic and Full_out/Empty_out. The top module holds Mem and the output registers.

## Test plan
- Reset, then write A0..A3 on consecutive cycles:
  - Count_out goes 1,2,3,4.
  - Full_out = 1 after the 4th write.
  - A fifth write of A4 is dropped and Count_out stays 4.
- Continuing from the full state, pulse ReadEn_in twice:
  - First read → Data_valid with (A0, A1).
  - Second read → Data_valid with (A2, A3).
  - Empty_out = 1 and Count_out = 0.
- Odd leftover: write B0, then ReadEn_in = 1 held.
  - No Data_valid while cnt = 1.
  - Write B1 → the next cycle accepts the read; (B0, B1) appears one cycle later.
- Simultaneous events: with cnt = 2 (C0, C1), assert write C2 and read together.
  - Output is (C0, C1); Count_out = 1.
  - Repeat at cnt = 4: the write is dropped and Count_out = 2.
- Wrap-around: stream 20 entries D0..D19 at 1 per cycle with a read every other cycle.
  - Pairs come out in order (D0, D1)…(D18, D19).
  - No drops; Full_out never asserts.
- Reset mid-operation: with cnt = 3, assert Clear_in together with WriteEn_in and ReadEn_in.
  - Next cycle: Count_out = 0, Empty_out = 1, Data_valid = 0, Data_out_1/2 = 0.

Source files
------------

// File: rtl/sfifo_1w_2r_pkg.sv
// Shared constants for the one-write / two-read FIFO: the SMEM entry width used as
// the default data width, and the accept-strobe bundle passed from the pointer block.
package sfifo_1w_2r_pkg;

  localparam int SMEM_ENTRY_W = 65;
  localparam int SFIFO_ADDR_W = 2;

  typedef struct packed {
    logic wr_acc;
    logic rd_acc;
  } sfifo_acc_t;

endpackage

// File: rtl/sfifo_1w_2r_if.sv
// Producer/consumer signal bundle for sfifo_1w_2r. The FIFO side is the slave.
//
// Handshake: an entry on Data_in is taken on a cycle with WriteEn_in & ~Full_out.
// A pair is popped on a cycle with ReadEn_in & ~Empty_out, and it appears on
// Data_out_1 (older) / Data_out_2 (newer) the next cycle with a one-cycle Data_valid.
// A request that is not accepted is dropped, so the requester holds it until accepted.
interface sfifo_1w_2r_if #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 2
) ();

  logic [DATA_WIDTH-1:0]    Data_in;
  logic                     WriteEn_in;
  logic                     Full_out;
  logic                     ReadEn_in;
  logic                     Empty_out;
  logic [DATA_WIDTH-1:0]    Data_out_1;
  logic [DATA_WIDTH-1:0]    Data_out_2;
  logic                     Data_valid;
  logic [ADDRESS_WIDTH:0]   Count_out;

  modport slave (
    input  Data_in, WriteEn_in, ReadEn_in,
    output Full_out, Empty_out, Data_out_1, Data_out_2, Data_valid, Count_out
  );

  modport master (
    output Data_in, WriteEn_in, ReadEn_in,
    input  Full_out, Empty_out, Data_out_1, Data_out_2, Data_valid, Count_out
  );

endinterface

// File: rtl/sfifo_1w_2r_ptr.sv
// Pointer/occupancy block for sfifo_1w_2r: write and pair-read pointers, the exact
// occupancy counter, the accept strobes and the Full/Empty flags.
module fifo_ptr_1w_2r
  import sfifo_1w_2r_pkg::*;
#(
  parameter int ADDRESS_WIDTH = SFIFO_ADDR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic                     rd_en_i,
  output sfifo_acc_t               acc_o,
  output logic [ADDRESS_WIDTH-1:0] wr_ptr_o,
  output logic [ADDRESS_WIDTH-1:0] rd_ptr_o,
  output logic [ADDRESS_WIDTH:0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int              AW         = ADDRESS_WIDTH;
  localparam int              CW         = ADDRESS_WIDTH + 1;
  localparam int              FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_acc, rd_acc;

  // Flags come from the registered count, so a full FIFO refuses a write even when
  // a read in the same cycle frees space. Clear masks both accepts.
  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q < CW'(2));
  assign wr_acc  = wr_en_i & ~full_o  & ~rst_i;
  assign rd_acc  = rd_en_i & ~empty_o & ~rst_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_d + CW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(2);
      cnt_d    = cnt_d - CW'(2);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o.wr_acc = wr_acc;
  assign acc_o.rd_acc = rd_acc;
  assign wr_ptr_o     = wr_ptr_q;
  assign rd_ptr_o     = rd_ptr_q;
  assign cnt_o        = cnt_q;

endmodule

// File: rtl/sfifo_1w_2r.sv
// Single-clock FIFO taking one entry per write and releasing two entries per read.
// Holds the storage array and the registered pair outputs; pointers live in fifo_ptr_1w_2r.
module sfifo_1w_2r
  import sfifo_1w_2r_pkg::*;
#(
  parameter int DATA_WIDTH    = SMEM_ENTRY_W,
  parameter int ADDRESS_WIDTH = SFIFO_ADDR_W
) (
  input  logic          Clk,
  input  logic          Clear_in,
  sfifo_1w_2r_if.slave  fifo_io
);

  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;

  sfifo_acc_t                acc;
  logic [ADDRESS_WIDTH-1:0]  wr_ptr;
  logic [ADDRESS_WIDTH-1:0]  rd_ptr;
  logic [ADDRESS_WIDTH-1:0]  rd_ptr_odd;
  logic [ADDRESS_WIDTH:0]    cnt;
  logic                      full;
  logic                      empty;

  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     dout1_q, dout1_d;
  logic [DATA_WIDTH-1:0]     dout2_q, dout2_d;
  logic                      valid_q, valid_d;

  fifo_ptr_1w_2r #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ptr (
    .clk_i    (Clk),
    .rst_i    (Clear_in),
    .wr_en_i  (fifo_io.WriteEn_in),
    .rd_en_i  (fifo_io.ReadEn_in),
    .acc_o    (acc),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .cnt_o    (cnt),
    .full_o   (full),
    .empty_o  (empty)
  );

  // rd_ptr only ever holds even values, so the partner slot is rd_ptr with bit 0 set.
  assign rd_ptr_odd = {rd_ptr[ADDRESS_WIDTH-1:1], 1'b1};

  always_ff @(posedge Clk) begin
    if (acc.wr_acc) begin
      mem_q[wr_ptr] <= fifo_io.Data_in;
    end
  end

  always_comb begin
    dout1_d = dout1_q;
    dout2_d = dout2_q;
    valid_d = acc.rd_acc;
    if (acc.rd_acc) begin
      dout1_d = mem_q[rd_ptr];
      dout2_d = mem_q[rd_ptr_odd];
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      dout1_q <= '0;
      dout2_q <= '0;
      valid_q <= 1'b0;
    end else begin
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      valid_q <= valid_d;
    end
  end

  assign fifo_io.Full_out   = full;
  assign fifo_io.Empty_out  = empty;
  assign fifo_io.Count_out  = cnt;
  assign fifo_io.Data_out_1 = dout1_q;
  assign fifo_io.Data_out_2 = dout2_q;
  assign fifo_io.Data_valid = valid_q;

endmodule
